// File: rtl/i2c_target.sv
// I2C target: fixed 7-bit address, ACKs every write byte, serves read
// bytes from tx_data. Open-drain SDA only; SCL is never stretched.
module i2c_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       addressed,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA,
    WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  logic scl_s1, scl_s2, scl_p;
  logic sda_s1, sda_s2, sda_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_p  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_p  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_p  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_p  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, scl_hi;
  logic start, stop;

  assign scl_rise = scl_s2 & ~scl_p;
  assign scl_fall = ~scl_s2 & scl_p;
  assign scl_hi   = scl_s2 & scl_p;
  assign start    = scl_hi & sda_p & ~sda_s2;
  assign stop     = scl_hi & ~sda_p & sda_s2;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] sh, sh_n;
  logic [7:0] shifted;
  logic       rw, rw_n;
  logic       done, done_n;
  logic       oe_n, adr_n;
  logic [7:0] rxd_n;
  logic       rxv_n, txl_n, stp_n;

  assign shifted = {sh[6:0], sda_s2};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      sh        <= 8'h00;
      rw        <= 1'b0;
      done      <= 1'b0;
      sda_oe    <= 1'b0;
      addressed <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      rw        <= rw_n;
      done      <= done_n;
      sda_oe    <= oe_n;
      addressed <= adr_n;
      rx_data   <= rxd_n;
      rx_valid  <= rxv_n;
      tx_load   <= txl_n;
      stop_det  <= stp_n;
    end
  end

  // done marks a completed byte whose ACK slot opens on the next scl_fall
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    rw_n    = rw;
    done_n  = done;
    oe_n    = sda_oe;
    adr_n   = addressed;
    rxd_n   = rx_data;
    rxv_n   = 1'b0;
    txl_n   = 1'b0;
    stp_n   = 1'b0;
    if (stop) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      adr_n   = 1'b0;
      done_n  = 1'b0;
      stp_n   = 1'b1;
    end else if (start) begin
      state_n = ADDR;
      cnt_n   = 3'd0;
      oe_n    = 1'b0;
      adr_n   = 1'b0;
      done_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            sh_n  = shifted;
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (sh[6:0] == SLAVE_ADDR) begin
                rw_n   = sda_s2;
                done_n = 1'b1;
              end else begin
                state_n = IGNORE;
              end
            end
          end else if (scl_fall && done) begin
            done_n  = 1'b0;
            oe_n    = 1'b1;
            state_n = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            adr_n = 1'b1;
            if (rw) begin
              txl_n   = 1'b1;
              oe_n    = ~tx_data[7];
              sh_n    = {tx_data[6:0], 1'b0};
              cnt_n   = 3'd1;
              state_n = RD_DATA;
            end else begin
              oe_n    = 1'b0;
              cnt_n   = 3'd0;
              state_n = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            sh_n  = shifted;
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd7) begin
              rxd_n  = shifted;
              rxv_n  = 1'b1;
              done_n = 1'b1;
            end
          end else if (scl_fall && done) begin
            done_n  = 1'b0;
            oe_n    = 1'b1;
            state_n = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            oe_n    = 1'b0;
            cnt_n   = 3'd0;
            state_n = WR_DATA;
          end
        end
        // cnt counts bits already driven; wrap to 0 means all 8 are out
        RD_DATA: begin
          if (scl_fall) begin
            if (cnt == 3'd0) begin
              oe_n    = 1'b0;
              done_n  = 1'b0;
              state_n = RD_ACK;
            end else begin
              oe_n  = ~sh[7];
              sh_n  = {sh[6:0], 1'b0};
              cnt_n = cnt + 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s2) begin
              oe_n    = 1'b0;
              state_n = IGNORE;
            end else begin
              done_n = 1'b1;
            end
          end else if (scl_fall && done) begin
            done_n  = 1'b0;
            txl_n   = 1'b1;
            oe_n    = ~tx_data[7];
            sh_n    = {tx_data[6:0], 1'b0};
            cnt_n   = 3'd1;
            state_n = RD_DATA;
          end
        end
        IGNORE: oe_n = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged open-drain master plus pulse
// monitors, directed scenarios, then random transactions vs a model.
module tb_i2c_target;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_oe, addressed, rx_valid, tx_load, stop_det;
  logic [7:0] rx_data, tx_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .addressed (addressed),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .stop_det  (stop_det)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rx_cnt = 0, tl_cnt = 0, sd_cnt = 0;
  int oe_cnt = 0, ad_cnt = 0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_q.push_back(rx_data);
    end
    if (tx_load)   tl_cnt++;
    if (stop_det)  sd_cnt++;
    if (sda_oe)    oe_cnt++;
    if (addressed) ad_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(Q);
    r = sda_bus;  tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
    i2c_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_bits(output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      i2c_bit(1'b1, r);
      d = {d[6:0], r};
    end
  endtask

  logic       ack, r;
  logic [7:0] got;
  int         rx0, tl0, sd0, oe0, ad0;

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
    tick(5);
    rst = 1'b0;
    tick(5);
    chk("rst_oe", {31'b0, sda_oe}, 0);
    chk("rst_addressed", {31'b0, addressed}, 0);
    chk("rst_rx_data", {24'b0, rx_data}, 0);
    chk("rst_rx_valid", {31'b0, rx_valid}, 0);
    chk("rst_tx_load", {31'b0, tx_load}, 0);
    chk("rst_stop_det", {31'b0, stop_det}, 0);

    // write 0xAB to 0x50
    rx0 = rx_cnt; sd0 = sd_cnt;
    i2c_start();
    wr_byte(8'hA0, ack);
    chk("w_addr_ack", {31'b0, ack}, 1);
    chk("w_addressed", {31'b0, addressed}, 1);
    wr_byte(8'hAB, ack);
    chk("w_data_ack", {31'b0, ack}, 1);
    i2c_stop();
    tick(4);
    chk("w_rx_cnt", rx_cnt - rx0, 1);
    chk("w_rx_data", {24'b0, rx_data}, 32'hAB);
    chk("w_stop_cnt", sd_cnt - sd0, 1);
    chk("w_unaddressed", {31'b0, addressed}, 0);

    // wrong address
    rx0 = rx_cnt; oe0 = oe_cnt; ad0 = ad_cnt;
    i2c_start();
    wr_byte(8'hA2, ack);
    chk("na_addr_ack", {31'b0, ack}, 0);
    wr_byte(8'h55, ack);
    chk("na_data_ack", {31'b0, ack}, 0);
    i2c_stop();
    chk("na_oe", oe_cnt - oe0, 0);
    chk("na_addressed", ad_cnt - ad0, 0);
    chk("na_rx", rx_cnt - rx0, 0);

    // two-byte read, ACK then NACK
    tx_data = 8'h3C; tl0 = tl_cnt;
    i2c_start();
    wr_byte(8'hA1, ack);
    chk("r_addr_ack", {31'b0, ack}, 1);
    rd_bits(got);
    chk("r_byte0", {24'b0, got}, 32'h3C);
    tx_data = 8'hC5;
    i2c_bit(1'b0, r);
    rd_bits(got);
    chk("r_byte1", {24'b0, got}, 32'hC5);
    i2c_bit(1'b1, r);
    chk("r_release", {31'b0, sda_oe}, 0);
    chk("r_tx_load", tl_cnt - tl0, 2);
    oe0 = oe_cnt;
    rd_bits(got);
    chk("r_ignore_bus", {24'b0, got}, 32'hFF);
    chk("r_ignore_oe", oe_cnt - oe0, 0);
    chk("r_ignore_load", tl_cnt - tl0, 2);
    i2c_stop();

    // write then repeated START into a read
    i2c_start();
    wr_byte(8'hA0, ack);
    chk("rs_waddr_ack", {31'b0, ack}, 1);
    wr_byte(8'h12, ack);
    chk("rs_wdata_ack", {31'b0, ack}, 1);
    sd0 = sd_cnt; tx_data = 8'h77;
    i2c_start();
    wr_byte(8'hA1, ack);
    chk("rs_raddr_ack", {31'b0, ack}, 1);
    rd_bits(got);
    chk("rs_rdata", {24'b0, got}, 32'h77);
    i2c_bit(1'b1, r);
    chk("rs_rx_data", {24'b0, rx_data}, 32'h12);
    chk("rs_no_stop", sd_cnt - sd0, 0);
    i2c_stop();

    // STOP after half a byte
    rx0 = rx_cnt; sd0 = sd_cnt;
    i2c_start();
    wr_byte(8'hA0, ack);
    chk("p_addr_ack", {31'b0, ack}, 1);
    i2c_bit(1'b1, r); i2c_bit(1'b0, r);
    i2c_bit(1'b1, r); i2c_bit(1'b1, r);
    i2c_stop();
    tick(4);
    chk("p_no_rx", rx_cnt - rx0, 0);
    chk("p_stop", sd_cnt - sd0, 1);
    chk("p_unaddressed", {31'b0, addressed}, 0);

    // reset while the target holds the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(i == 0 ? 1'b0 : (8'hA0 >> i) & 1'b1, r);
    sda_m = 1'b1;
    tick(Q);
    chk("x_oe_before", {31'b0, sda_oe}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("x_oe_after", {31'b0, sda_oe}, 0);
    @(negedge clk);
    rst = 1'b0;
    scl_m = 1'b1;
    tick(Q);
    rx0 = rx_cnt;
    i2c_start();
    wr_byte(8'hA0, ack);
    chk("x_addr_ack", {31'b0, ack}, 1);
    wr_byte(8'h5A, ack);
    chk("x_data_ack", {31'b0, ack}, 1);
    i2c_stop();
    chk("x_rx_cnt", rx_cnt - rx0, 1);
    chk("x_rx_data", {24'b0, rx_data}, 32'h5A);

    // random transactions against a transaction-level model
    for (int t = 0; t < 8; t++) begin
      logic [6:0] addr;
      logic       rw, hit;
      logic [7:0] d[3];
      int         n;
      addr = $urandom_range(0, 1) ? 7'h50 : 7'($urandom);
      if (addr == 7'h50 && t[0]) addr = 7'h51;
      rw   = 1'($urandom);
      n    = $urandom_range(1, 3);
      for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
      hit  = (addr == 7'h50);
      rx_q.delete();
      tl0 = tl_cnt;
      tx_data = d[0];
      i2c_start();
      wr_byte({addr, rw}, ack);
      chk("rnd_addr_ack", {31'b0, ack}, {31'b0, hit});
      for (int i = 0; i < n; i++) begin
        if (!rw) begin
          wr_byte(d[i], ack);
          chk("rnd_wr_ack", {31'b0, ack}, {31'b0, hit});
        end else begin
          rd_bits(got);
          chk("rnd_rd", {24'b0, got}, hit ? {24'b0, d[i]} : 32'hFF);
          if (i < n - 1) tx_data = d[i + 1];
          i2c_bit(i == n - 1, r);
        end
      end
      i2c_stop();
      chk("rnd_rx_n", rx_q.size(), (hit && !rw) ? n : 0);
      if (hit && !rw && rx_q.size() == n)
        for (int i = 0; i < n; i++)
          chk("rnd_rx_byte", {24'b0, rx_q[i]}, {24'b0, d[i]});
      chk("rnd_tx_load", tl_cnt - tl0, (hit && rw) ? n : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
